// File: rtl/dsp_pipe_pkg.sv
// dsp_pipe_pkg: shared defaults and the occupancy-width helper for the elastic pipe.
// Contents:
//   DEF_WIDTH  default data width per stage
//   DEF_DEPTH  default number of register stages
//   cnt_w()    occupancy counter width, clamped to at least 1 so that DEPTH=0 stays legal
package dsp_pipe_pkg;

    localparam int DEF_WIDTH = 18;
    localparam int DEF_DEPTH = 2;

    function automatic int cnt_w(input int depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: one elastic register slot (valid + data) with its ready term.
// Ports:
//   clk, rst_aSYNC  rising-edge clock, asynchronous active-high reset
//   flush           synchronous clear of the valid bit (data is kept)
//   prev_valid      valid offered by the predecessor
//   prev_data       data offered by the predecessor
//   next_ready      ready of the successor (or of the downstream port)
//   ready           this slot can take a word: empty, or draining this cycle
//   valid, data     registered slot contents
module dsp_pipe_stage #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_aSYNC,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = !valid | next_ready;

    // Data only loads alongside a valid load, so a stalled or empty slot keeps its last word.
    always_ff @(posedge clk or posedge rst_aSYNC) begin
        if (rst_aSYNC) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (ready)
                valid <= prev_valid;
            if (!flush && ready && prev_valid)
                data <= prev_data;
        end
    end

endmodule

// File: rtl/dsp_elastic_pipe.sv
// dsp_elastic_pipe: DEPTH-stage valid/ready register chain with bubble collapse, flush and occupancy.
// Ports:
//   clk, rst_aSYNC        rising-edge clock, asynchronous active-high reset
//   flush_i               synchronous clear of all stage valids, occupancy and par_err
//   in_valid/in_ready     upstream handshake, in_data upstream word
//   out_valid/out_ready   downstream handshake, out_data last-stage word
//   occupancy             number of valid stages (0..DEPTH)
//   par_err               sticky parity error
// Optional feature: define DSP_PIPE_PARITY_EN to carry an even-parity bit with every word and
// flag a mismatch at the output; otherwise par_err is tied 0.
module dsp_elastic_pipe
    import dsp_pipe_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_aSYNC,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             par_err
);

`ifdef DSP_PIPE_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid & !flush_i;
            assign in_ready  = out_ready & !flush_i;
            assign out_data  = in_data;
            assign occupancy = '0;
            assign par_err   = 1'b0;
        end else begin : g_pipe
            logic          v [DEPTH+1];
            logic          r [DEPTH+1];
            logic [SW-1:0] d [DEPTH+1];
            logic          in_xfer;
            logic          out_xfer;

            assign v[0] = in_valid;
`ifdef DSP_PIPE_PARITY_EN
            // Parity sits above the data bits so it travels through the stages with its word.
            assign d[0] = {^in_data, in_data};
`else
            assign d[0] = in_data;
`endif
            assign r[DEPTH] = out_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_st
                dsp_pipe_stage #(.WIDTH(SW)) u_stage (
                    .clk       (clk),
                    .rst_aSYNC (rst_aSYNC),
                    .flush     (flush_i),
                    .prev_valid(v[k]),
                    .prev_data (d[k]),
                    .next_ready(r[k+1]),
                    .ready     (r[k]),
                    .valid     (v[k+1]),
                    .data      (d[k+1])
                );
            end

            assign in_ready  = r[0] & !flush_i;
            assign out_valid = v[DEPTH];
            assign out_data  = d[DEPTH][WIDTH-1:0];
            assign in_xfer   = in_valid & in_ready;
            assign out_xfer  = out_valid & out_ready;

            always_ff @(posedge clk or posedge rst_aSYNC) begin
                if (rst_aSYNC)
                    occupancy <= '0;
                else if (flush_i)
                    occupancy <= '0;
                else
                    occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
            end

`ifdef DSP_PIPE_PARITY_EN
            always_ff @(posedge clk or posedge rst_aSYNC) begin
                if (rst_aSYNC)
                    par_err <= 1'b0;
                else if (flush_i)
                    par_err <= 1'b0;
                else if (out_xfer && ((^out_data) != d[DEPTH][WIDTH]))
                    par_err <= 1'b1;
            end
`else
            assign par_err = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dsp_elastic_pipe.sv
// tb_dsp_elastic_pipe: directed checks of the default DSP elastic pipe (WIDTH=18, DEPTH=2).
module tb_dsp_elastic_pipe;

    logic        clk = 1'b0;
    logic        rst_aSYNC = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_data;
    logic [1:0]  occupancy;
    logic        par_err;

    int n_cmp = 0;
    int n_err = 0;

    dsp_elastic_pipe dut (
        .clk       (clk),
        .rst_aSYNC (rst_aSYNC),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later still.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst_aSYNC = 1'b0;
        tick();

        // 1. stream 0x001..0x010 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            in_valid = (i <= 16);
            in_data  = 18'(i);
            #1;
            chk("stream_out_valid", 32'(out_valid), (i >= 3) ? 32'd1 : 32'd0);
            chk("stream_out_data", 32'(out_data), (i >= 3) ? 32'(i - 2) : 32'd0);
            chk("stream_occupancy", 32'(occupancy), (i == 1) ? 32'd0 : (i == 2 || i == 18) ? 32'd1 : 32'd2);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_occupancy", 32'(occupancy), 32'd0);
        chk("empty_holds_data", 32'(out_data), 32'h10);

        // 2. stall with two words, then simultaneous in/out while full, then drain
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 18'h001;
        tick();
        in_data = 18'h002;
        tick();
        in_data = 18'h003;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_occupancy", 32'(occupancy), 32'd2);
        chk("stall_out_data", 32'(out_data), 32'h001);
        tick();
        #1;
        chk("frozen_out_data", 32'(out_data), 32'h001);
        chk("frozen_occupancy", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        #1;
        chk("full_pass_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_pass_occupancy", 32'(occupancy), 32'd2);
        chk("release_first", 32'(out_data), 32'h002);
        tick();
        #1;
        chk("release_third", 32'(out_data), 32'h003);
        chk("release_occupancy", 32'(occupancy), 32'd1);
        tick();
        #1;
        chk("release_empty", 32'(out_valid), 32'd0);

        // 3. bubble collapse while downstream stalls
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 18'h00A;
        tick();
        in_valid = 1'b0;
        #1;
        chk("bubble_occ_1", 32'(occupancy), 32'd1);
        chk("bubble_not_out", 32'(out_valid), 32'd0);
        tick();
        #1;
        chk("bubble_reached_out", 32'(out_valid), 32'd1);
        chk("bubble_out_data", 32'(out_data), 32'h00A);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = 18'h00B;
        tick();
        in_valid = 1'b0;
        #1;
        chk("bubble_full_occ", 32'(occupancy), 32'd2);
        chk("bubble_full_ready", 32'(in_ready), 32'd0);

        // 4. flush of a full chain
        flush_i = 1'b1;
        in_valid = 1'b1;
        in_data = 18'h00C;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush_i = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_data_kept", 32'(out_data), 32'h00A);
        chk("flush_after_ready", 32'(in_ready), 32'd1);

        // 5. asynchronous reset between edges
        in_valid = 1'b1;
        in_data = 18'h011;
        tick();
        in_data = 18'h012;
        tick();
        in_valid = 1'b0;
        #1;
        chk("pre_reset_occ", 32'(occupancy), 32'd2);
        rst_aSYNC = 1'b1;
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_occupancy", 32'(occupancy), 32'd0);
        chk("areset_out_data", 32'(out_data), 32'd0);
        #1 rst_aSYNC = 1'b0;
        tick();
        #1;
        chk("post_reset_occ", 32'(occupancy), 32'd0);

`ifdef DSP_PIPE_PARITY_EN
        // 6. corrupt the last stage and check the sticky parity error
        in_valid = 1'b1;
        in_data = 18'h0AA;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("par_clean", 32'(par_err), 32'd0);
        force dut.g_pipe.g_st[1].u_stage.data = {1'b0, 18'h0AB};
        out_ready = 1'b1;
        tick();
        release dut.g_pipe.g_st[1].u_stage.data;
        tick();
        #1;
        chk("par_err_set", 32'(par_err), 32'd1);
        tick();
        #1;
        chk("par_err_sticky", 32'(par_err), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("par_err_flushed", 32'(par_err), 32'd0);
`else
        chk("par_err_tied", 32'(par_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
